multi_lag_correlator: RTL and testbench

Parametrised multi-channel integrate-and-dump correlator for the spread-spectrum receiver. Each of NCH channels accumulates the shared input sample multiplied by its own ±1 chip over a programmable window of DUMP_LEN samples. At window end it dumps all channel sums into an output register held under a valid/ready handshake. Sits between the sample front end and the peak/lag-detection logic; one channel per code phase (lag) under test.

---
 rtl/multi_lag_correlator.sv | 122 ++++++++++++
 tb/tb_multi_lag_correlator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lag_correlator.sv
// Multi-channel integrate-and-dump correlator: each channel accumulates +/-samp per its chip
// over a programmable window and dumps all sums into a valid/ready-held output register.
module multi_lag_correlator #(
  parameter int SAMP_W = 12,
  parameter int ACC_W  = 32,
  parameter int NCH    = 4,
  parameter int LEN_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_sync,
  input  logic                     i_push_samp,
  input  logic signed [SAMP_W-1:0] i_samp,
  input  logic [NCH-1:0]           i_code,
  input  logic [LEN_W-1:0]         i_dump_len,
  output logic                     o_corr_valid,
  input  logic                     i_corr_ready,
  output logic [NCH*ACC_W-1:0]     o_corr_out,
  output logic [NCH-1:0]           o_sat,
  output logic                     o_overrun
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic signed [ACC_W:0] MAX_V = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {2'b11, {(ACC_W-1){1'b0}}};

  state_t                    r_state;
  logic [NCH-1:0][ACC_W-1:0] r_acc;
  logic [NCH-1:0]            r_sat_int;
  logic [LEN_W-1:0]          r_cnt;
  logic [LEN_W-1:0]          r_len;
  logic [NCH*ACC_W-1:0]      r_corr_out;
  logic [NCH-1:0]            r_sat;
  logic                      r_corr_valid;
  logic                      r_overrun;

  logic [NCH-1:0][ACC_W-1:0] w_acc_nxt;
  logic [NCH-1:0]            w_ovf;
  logic [LEN_W-1:0]          w_len_eff;
  logic [LEN_W-1:0]          w_cnt_inc;
  logic                      w_push;
  logic                      w_dump;
  logic                      w_xfer;

  // Returns {overflow, clamped sum}; the ACC_W+1 intermediate cannot itself overflow since ACC_W > SAMP_W.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic signed [SAMP_W-1:0] s,
                                             input logic pos);
    logic signed [ACC_W:0] term;
    logic signed [ACC_W:0] sum;
    term = (ACC_W+1)'(s);
    if (!pos) term = -term;
    else      term = term;
    sum = $signed({acc[ACC_W-1], acc}) + term;
    if (sum > MAX_V)      return {1'b1, MAX_V[ACC_W-1:0]};
    else if (sum < MIN_V) return {1'b1, MIN_V[ACC_W-1:0]};
    else                  return {1'b0, sum[ACC_W-1:0]};
  endfunction

  // Next accumulator value and overflow flag for every channel
  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf     = '0;
    for (int k = 0; k < NCH; k++) begin
      {w_ovf[k], w_acc_nxt[k]} = sat_add(r_acc[k], i_samp, i_code[k]);
    end
  end

  assign w_len_eff = (i_dump_len == '0) ? LEN_W'(1) : i_dump_len;
  assign w_cnt_inc = r_cnt + LEN_W'(1);
  assign w_push    = (r_state == ST_RUN) && i_push_samp;
  assign w_dump    = w_push && (w_cnt_inc == r_len);
  assign w_xfer    = r_corr_valid && i_corr_ready;

  // Control FSM, window accumulation and output register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_sat_int    <= '0;
      r_cnt        <= '0;
      r_len        <= LEN_W'(1);
      r_corr_out   <= '0;
      r_sat        <= '0;
      r_corr_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (i_sync) begin
      // sync dominates any push or dump in the same cycle; the last result stays visible
      r_state      <= ST_RUN;
      r_acc        <= '0;
      r_sat_int    <= '0;
      r_cnt        <= '0;
      r_len        <= w_len_eff;
      r_sat        <= '0;
      r_corr_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_dump) begin
      r_corr_out   <= w_acc_nxt;
      r_sat        <= r_sat_int | w_ovf;
      r_corr_valid <= 1'b1;
      r_overrun    <= r_overrun | (r_corr_valid & ~i_corr_ready);
      r_acc        <= '0;
      r_sat_int    <= '0;
      r_cnt        <= '0;
      r_len        <= w_len_eff;
    end else if (w_push) begin
      r_acc        <= w_acc_nxt;
      r_sat_int    <= r_sat_int | w_ovf;
      r_cnt        <= w_cnt_inc;
      r_corr_valid <= r_corr_valid & ~w_xfer;
    end else begin
      r_corr_valid <= r_corr_valid & ~w_xfer;
    end
  end

  assign o_corr_valid = r_corr_valid;
  assign o_corr_out   = r_corr_out;
  assign o_sat        = r_sat;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_multi_lag_correlator.sv
// Bench for multi_lag_correlator: directed scenarios plus randomized traffic against an
// arithmetic window model, on a wide 4-channel instance and a narrow 2-channel instance.
module tb_multi_lag_correlator;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sync = 1'b0;
  logic               push = 1'b0;
  logic signed [11:0] samp = 12'sd0;
  logic [3:0]         code = 4'b0000;
  logic [15:0]        dump_len = 16'd1;
  logic               ready = 1'b0;

  logic         a_valid, b_valid;
  logic [127:0] a_out;
  logic [27:0]  b_out;
  logic [3:0]   a_sat;
  logic [1:0]   b_sat;
  logic         a_ovr, b_ovr;

  int n_cmp = 0;
  int n_fail = 0;

  multi_lag_correlator #(.SAMP_W(12), .ACC_W(32), .NCH(4), .LEN_W(16)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_sync(sync), .i_push_samp(push), .i_samp(samp),
    .i_code(code), .i_dump_len(dump_len), .o_corr_valid(a_valid), .i_corr_ready(ready),
    .o_corr_out(a_out), .o_sat(a_sat), .o_overrun(a_ovr));

  multi_lag_correlator #(.SAMP_W(12), .ACC_W(14), .NCH(2), .LEN_W(16)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_sync(sync), .i_push_samp(push), .i_samp(samp),
    .i_code(code[1:0]), .i_dump_len(dump_len), .o_corr_valid(b_valid), .i_corr_ready(ready),
    .o_corr_out(b_out), .o_sat(b_sat), .o_overrun(b_ovr));

  always #5 clk = ~clk;

  // Reference model: index 0 = 32-bit/4-channel instance, 1 = 14-bit/2-channel instance
  bit     m_run[2];
  longint m_acc[2][4];
  bit     m_si[2][4];
  int     m_cnt[2];
  int     m_len[2];
  longint m_out[2][4];
  bit     m_sat[2][4];
  bit     m_valid[2];
  bit     m_ovr[2];

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int nch;
      longint mx, mn, v;
      bit xfer;
      nch = (i == 0) ? 4 : 2;
      mx = (i == 0) ? 64'sd2147483647 : 64'sd8191;
      mn = -mx - 64'sd1;
      xfer = m_valid[i] && ready;
      if (reset) begin
        m_run[i] = 1'b0; m_cnt[i] = 0; m_len[i] = 1; m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          m_acc[i][k] = 0; m_si[i][k] = 1'b0; m_out[i][k] = 0; m_sat[i][k] = 1'b0;
        end
      end else if (sync) begin
        m_run[i] = 1'b1; m_cnt[i] = 0; m_len[i] = (dump_len == 16'd0) ? 1 : int'(dump_len);
        m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          m_acc[i][k] = 0; m_si[i][k] = 1'b0; m_sat[i][k] = 1'b0;
        end
      end else if (m_run[i] && push) begin
        for (int k = 0; k < nch; k++) begin
          v = m_acc[i][k] + (code[k] ? longint'(samp) : -longint'(samp));
          if (v > mx) begin v = mx; m_si[i][k] = 1'b1; end
          if (v < mn) begin v = mn; m_si[i][k] = 1'b1; end
          m_acc[i][k] = v;
        end
        m_cnt[i]++;
        if (m_cnt[i] == m_len[i]) begin
          if (m_valid[i] && !xfer) m_ovr[i] = 1'b1;
          m_valid[i] = 1'b1;
          for (int k = 0; k < 4; k++) begin
            m_out[i][k] = m_acc[i][k]; m_sat[i][k] = m_si[i][k];
            m_acc[i][k] = 0; m_si[i][k] = 1'b0;
          end
          m_cnt[i] = 0;
          m_len[i] = (dump_len == 16'd0) ? 1 : int'(dump_len);
        end else if (xfer) begin
          m_valid[i] = 1'b0;
        end
      end else if (xfer) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", a_valid); end
    n_cmp++; if (a_out !== 128'd0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", a_out); end
    n_cmp++; if (a_sat !== 4'b0000) begin n_fail++; $display("FAIL reset_sat: got %b expected 0000", a_sat); end
    n_cmp++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b expected 0", a_ovr); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    push = 1'b1; dump_len = 16'd1; code = 4'b1111; samp = 12'sd50; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_dump: got %0b expected 0", a_valid); end
    end
    push = 1'b0;
  endtask

  task automatic test_basic();
    int vals[4] = '{10, 20, -5, 7};
    sync = 1'b1; dump_len = 16'd4; tick(); sync = 1'b0;
    code = 4'b0101; ready = 1'b1; push = 1'b1;
    for (int i = 0; i < 4; i++) begin samp = 12'(vals[i]); tick(); end
    push = 1'b0;
    n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", a_valid); end
    for (int k = 0; k < 4; k++) begin
      int e;
      e = code[k] ? 32 : -32;
      n_cmp++; if ($signed(a_out[k*32 +: 32]) !== e) begin n_fail++; $display("FAIL basic_ch%0d: got %0d expected %0d", k, $signed(a_out[k*32 +: 32]), e); end
    end
    n_cmp++; if (a_sat !== 4'b0000) begin n_fail++; $display("FAIL basic_sat: got %b expected 0000", a_sat); end
    tick();
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0b expected 0", a_valid); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0; sync = 1'b1; dump_len = 16'd2; tick(); sync = 1'b0;
    code = 4'b1111; samp = 12'sd100; push = 1'b1;
    tick(); tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0b expected 1", a_valid); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if ($signed(a_out[k*32 +: 32]) !== 200) begin n_fail++; $display("FAIL b2b_ch%0d: got %0d expected 200", k, $signed(a_out[k*32 +: 32])); end
    end
    n_cmp++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_no_overrun: got %0b expected 0", a_ovr); end
    tick(); tick();
    n_cmp++; if ($signed(a_out[31:0]) !== 200) begin n_fail++; $display("FAIL b2b_second_data: got %0d expected 200", $signed(a_out[31:0])); end
    n_cmp++; if (a_ovr !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %0b expected 1", a_ovr); end
    push = 1'b0; sync = 1'b1; tick(); sync = 1'b0;
    n_cmp++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_sync_ovr: got %0b expected 0", a_ovr); end
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_sync_valid: got %0b expected 0", a_valid); end
  endtask

  task automatic test_saturation();
    sync = 1'b1; dump_len = 16'd8; tick(); sync = 1'b0;
    code = 4'b0001; samp = 12'sd2047; ready = 1'b1; push = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %0b expected 1", b_valid); end
    n_cmp++; if ($signed(b_out[13:0]) !== 8191) begin n_fail++; $display("FAIL sat_ch0: got %0d expected 8191", $signed(b_out[13:0])); end
    n_cmp++; if ($signed(b_out[27:14]) !== -8192) begin n_fail++; $display("FAIL sat_ch1: got %0d expected -8192", $signed(b_out[27:14])); end
    n_cmp++; if (b_sat !== 2'b11) begin n_fail++; $display("FAIL sat_flags: got %b expected 11", b_sat); end
    samp = 12'sd1;
    for (int i = 0; i < 8; i++) tick();
    push = 1'b0;
    n_cmp++; if ($signed(b_out[13:0]) !== 8) begin n_fail++; $display("FAIL clean_ch0: got %0d expected 8", $signed(b_out[13:0])); end
    n_cmp++; if ($signed(b_out[27:14]) !== -8) begin n_fail++; $display("FAIL clean_ch1: got %0d expected -8", $signed(b_out[27:14])); end
    n_cmp++; if (b_sat !== 2'b00) begin n_fail++; $display("FAIL clean_sat: got %b expected 00", b_sat); end
  endtask

  task automatic test_simultaneous();
    ready = 1'b0; sync = 1'b1; dump_len = 16'd2; tick(); sync = 1'b0;
    code = 4'b1111; push = 1'b1; samp = 12'sd5; tick(); tick();
    samp = 12'sd7; tick();
    ready = 1'b1; tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL simul_valid: got %0b expected 1", a_valid); end
    n_cmp++; if ($signed(a_out[31:0]) !== 14) begin n_fail++; $display("FAIL simul_data: got %0d expected 14", $signed(a_out[31:0])); end
    n_cmp++; if (a_ovr !== 1'b0) begin n_fail++; $display("FAIL simul_overrun: got %0b expected 0", a_ovr); end
    ready = 1'b0; sync = 1'b1; samp = 12'sd1000; tick(); sync = 1'b0;
    samp = 12'sd3; tick(); samp = 12'sd4; tick();
    push = 1'b0;
    n_cmp++; if ($signed(a_out[31:0]) !== 7) begin n_fail++; $display("FAIL sync_push_ch0: got %0d expected 7", $signed(a_out[31:0])); end
    n_cmp++; if ($signed(a_out[127:96]) !== 7) begin n_fail++; $display("FAIL sync_push_ch3: got %0d expected 7", $signed(a_out[127:96])); end
  endtask

  task automatic test_len_zero();
    ready = 1'b1; sync = 1'b1; dump_len = 16'd0; tick(); sync = 1'b0;
    code = 4'b0011; push = 1'b1; samp = 12'sd9; tick();
    n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL len0_valid: got %0b expected 1", a_valid); end
    n_cmp++; if ($signed(a_out[95:64]) !== -9) begin n_fail++; $display("FAIL len0_ch2: got %0d expected -9", $signed(a_out[95:64])); end
    samp = -12'sd4; tick(); push = 1'b0;
    n_cmp++; if ($signed(a_out[31:0]) !== -4) begin n_fail++; $display("FAIL len0_ch0: got %0d expected -4", $signed(a_out[31:0])); end
    n_cmp++; if (a_valid !== 1'b1 || a_ovr !== 1'b0) begin n_fail++; $display("FAIL len0_hs: got valid=%0b ovr=%0b expected 1/0", a_valid, a_ovr); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; sync = 1'b1; dump_len = 16'd5; tick(); sync = 1'b0;
    code = 4'b1010; push = 1'b1; samp = 12'sd33;
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (a_valid !== 1'b0 || a_out !== 128'd0 || a_sat !== 4'd0 || a_ovr !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got valid=%0b out=%h sat=%b ovr=%0b expected all 0", a_valid, a_out, a_sat, a_ovr);
    end
    dump_len = 16'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ignore: got %0b expected 0", a_valid); end
    end
    push = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] ea;
    logic [27:0]  eb;
    logic [3:0]   sa;
    logic [1:0]   sb;
    for (int c = 0; c < 1500; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      sync     = ($urandom_range(0, 39) == 0) || (c == 0);
      push     = ($urandom_range(0, 9) < 8);
      samp     = 12'($urandom);
      code     = 4'($urandom);
      dump_len = 16'($urandom_range(0, 9));
      ready    = ($urandom_range(0, 2) == 0);
      tick();
      for (int k = 0; k < 4; k++) begin ea[k*32 +: 32] = m_out[0][k][31:0]; sa[k] = m_sat[0][k]; end
      for (int k = 0; k < 2; k++) begin eb[k*14 +: 14] = m_out[1][k][13:0]; sb[k] = m_sat[1][k]; end
      n_cmp++; if (a_valid !== m_valid[0]) begin n_fail++; $display("FAIL rnd_a_valid c%0d: got %0b expected %0b", c, a_valid, m_valid[0]); end
      n_cmp++; if (a_out !== ea) begin n_fail++; $display("FAIL rnd_a_out c%0d: got %h expected %h", c, a_out, ea); end
      n_cmp++; if (a_sat !== sa) begin n_fail++; $display("FAIL rnd_a_sat c%0d: got %b expected %b", c, a_sat, sa); end
      n_cmp++; if (a_ovr !== m_ovr[0]) begin n_fail++; $display("FAIL rnd_a_ovr c%0d: got %0b expected %0b", c, a_ovr, m_ovr[0]); end
      n_cmp++; if (b_valid !== m_valid[1]) begin n_fail++; $display("FAIL rnd_b_valid c%0d: got %0b expected %0b", c, b_valid, m_valid[1]); end
      n_cmp++; if (b_out !== eb) begin n_fail++; $display("FAIL rnd_b_out c%0d: got %h expected %h", c, b_out, eb); end
      n_cmp++; if (b_sat !== sb) begin n_fail++; $display("FAIL rnd_b_sat c%0d: got %b expected %b", c, b_sat, sb); end
      n_cmp++; if (b_ovr !== m_ovr[1]) begin n_fail++; $display("FAIL rnd_b_ovr c%0d: got %0b expected %0b", c, b_ovr, m_ovr[1]); end
    end
    reset = 1'b0; sync = 1'b0; push = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_simultaneous();
    test_len_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
